// File: rtl/sprite_tile_rom_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_tile_rom_arbiter_pkg
// Description : Shared PPU defines: display/colour widths, sprite tile ROM
//               geometry defaults and packed-slice helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_tile_rom_arbiter_pkg;

    // Display-side widths shared across the PPU
    localparam int VGA_POSXY_BIT          = 10;
    localparam int RGB_BIT                = 12;

    // Sprite tile ROM arbiter defaults
    localparam int SPRITE_NUM_REQ         = 8;
    localparam int SPRITE_TILEROM_ADDRBIT = 10;
    localparam int SPRITE_TILEDATA_BIT    = 32;

    // Lowest bit of slice k in a vector packed with WIDTH-bit slices
    function automatic int unsigned slice_lo(input int unsigned k, input int unsigned width);
        return k * width;
    endfunction

    // Width of a pointer that addresses n requesters (at least one bit)
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_tile_rom_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. The search starts at ptr
//               and the first set request bit wins; grant is one-hot or zero.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int PTR_W   = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    // Requests rotated so that requester ptr sits at bit 0
    logic [NUM_REQ-1:0] rotated;
    logic [NUM_REQ-1:0] first;
    logic               found;

    assign rotated = NUM_REQ'({req, req} >> ptr);

    // Pick the lowest set bit of the rotated request vector
    always_comb begin
        first = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rotated[i]) begin
                first[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Rotate the winner back into requester numbering
    assign grant = NUM_REQ'(({first, first} << ptr) >> NUM_REQ);

endmodule
`default_nettype wire

// File: rtl/sprite_tile_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sprite_tile_rom_arbiter
// Description : Shares one single-port tile ROM among NUM_REQ sprite
//               tile-draw requesters. One round-robin read per cycle; the
//               address is driven combinationally from the grant and the data
//               is returned with a one-cycle ack the following cycle.
//               Optional feature macro: SPRITE_ARB_CACHE_EN adds a last-index
//               tag per requester so repeated fetches bypass the ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_tile_rom_arbiter
    import sprite_tile_rom_arbiter_pkg::*;
#(
    parameter int NUM_REQ = SPRITE_NUM_REQ,
    parameter int ADDR_W  = SPRITE_TILEROM_ADDRBIT,
    parameter int DATA_W  = SPRITE_TILEDATA_BIT
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      flush_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] idx_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic [NUM_REQ*DATA_W-1:0] data_o,
    output logic                      rom_en_o,
    output logic [ADDR_W-1:0]         rom_addr_o,
    input  logic [DATA_W-1:0]         rom_data_i
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    logic [ADDR_W-1:0]  idx [NUM_REQ];
    logic [DATA_W-1:0]  data_q [NUM_REQ];
    logic [NUM_REQ-1:0] ack_q;          // served last cycle, acked now
    logic [NUM_REQ-1:0] ack_prev;       // acked in the previous cycle
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] hit;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic               inflight_valid;
    logic [PTR_W-1:0]   inflight_idx;

    // Unpack per-requester index slices and present per-requester data;
    // the slice being filled this cycle shows the ROM data directly.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
        localparam int ALO = int'(slice_lo(k, ADDR_W));
        localparam int DLO = int'(slice_lo(k, DATA_W));
        assign idx[k] = idx_i[ALO +: ADDR_W];
        assign data_o[DLO +: DATA_W] =
            (inflight_valid && (inflight_idx == PTR_W'(k))) ? rom_data_i : data_q[k];
    end

    // A requester stays blocked while its stale request is still visible:
    // the ack cycle and the cycle after it. Gated by rstn so the ROM port
    // stays quiet during reset.
    assign eligible = rstn ? (req_i & ~ack_q & ~ack_prev) : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req   (eligible & ~hit),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Encode the one-hot grant and steer the winner's index to the ROM
    always_comb begin
        grant_idx  = '0;
        rom_addr_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                grant_idx  = PTR_W'(k);
                rom_addr_o = idx[k];
            end
        end
    end

    assign rom_en_o = |grant;
    assign ack_o    = ack_q;

    // Ack scheduling, in-flight tag and round-robin pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack_q          <= '0;
            ack_prev       <= '0;
            inflight_valid <= 1'b0;
            inflight_idx   <= '0;
            rr_ptr         <= '0;
        end else begin
            ack_q          <= grant | hit;
            ack_prev       <= ack_q;
            inflight_valid <= rom_en_o;
            inflight_idx   <= grant_idx;
            if (rom_en_o) begin
                rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
            end
        end
    end

    // Hold each requester's last ROM data until its next fill
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                data_q[k] <= '0;
            end
        end else if (inflight_valid) begin
            data_q[inflight_idx] <= rom_data_i;
        end
    end

`ifdef SPRITE_ARB_CACHE_EN
    logic [ADDR_W-1:0]  tag_q [NUM_REQ];
    logic [NUM_REQ-1:0] tag_valid;
    logic [ADDR_W-1:0]  inflight_addr;

    // An eligible request matching its requester's valid tag is a hit
    always_comb begin
        hit = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            hit[k] = eligible[k] & tag_valid[k] & (tag_q[k] == idx[k]);
        end
    end

    // Tag fill on ROM return; a line-start flush invalidates everything
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_valid     <= '0;
            inflight_addr <= '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            inflight_addr <= rom_addr_o;
            if (inflight_valid) begin
                tag_q[inflight_idx] <= inflight_addr;
            end
            if (flush_i) begin
                tag_valid <= '0;
            end else if (inflight_valid) begin
                tag_valid[inflight_idx] <= 1'b1;
            end
        end
    end
`else
    // No tag storage: every request goes to the ROM and flush has no effect
    logic unused_flush;
    assign hit          = '0;
    assign unused_flush = flush_i;
`endif

endmodule
`default_nettype wire
